// File: rtl/npc_pkg.sv
// Shared NPC constants: datapath widths, ALU one-hot bit positions and the reset PC.
package npc_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NREG     = 32;
  localparam int ALU_OP_W = 8;

  localparam int ALU_ADD_BIT  = 0;
  localparam int ALU_SUB_BIT  = 1;
  localparam int ALU_AND_BIT  = 2;
  localparam int ALU_OR_BIT   = 3;
  localparam int ALU_XOR_BIT  = 4;
  localparam int ALU_SLT_BIT  = 5;
  localparam int ALU_SLTU_BIT = 6;
  localparam int ALU_SLL_BIT  = 7;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/decoder3_8_oh.sv
// 3-to-8 one-hot decoder; exactly one output bit is set for every select value.
module decoder3_8_oh (
  input  logic [2:0] i_sel,
  output logic [7:0] o_onehot
);
  assign o_onehot = 8'd1 << i_sel;
endmodule

// File: rtl/exec_regfile_alu.sv
// Execute-stage core: 2R/1W register file with hard-wired x0, one-hot ALU and funct3 decoder.
module exec_regfile_alu
  import npc_pkg::*;
#(
  parameter int XLEN     = npc_pkg::XLEN,
  parameter int NREG     = npc_pkg::NREG,
  parameter int ALU_OP_W = npc_pkg::ALU_OP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen,
  input  logic [REG_AW-1:0]        waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [REG_AW-1:0]        raddr1,
  output logic [XLEN-1:0]          rdata1,
  input  logic [REG_AW-1:0]        raddr2,
  output logic [XLEN-1:0]          rdata2,
  input  logic [XLEN-1:0]          src1,
  input  logic [XLEN-1:0]          src2,
  input  logic [ALU_OP_W-1:0]      alu_op,
  output logic [XLEN-1:0]          alu_result,
  input  logic [2:0]               funct3,
  output logic [7:0]               funct3_d
);
  localparam int SHAMT_W = $clog2(XLEN);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wen && (waddr != '0)) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Reads are unbypassed: a same-cycle write becomes visible only after the edge.
  assign rdata1 = (raddr1 == '0) ? '0 : r_regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : r_regs[raddr2];

  logic signed [XLEN-1:0] w_src1_s;
  logic signed [XLEN-1:0] w_src2_s;
  logic                   w_lt_s;
  logic                   w_lt_u;
  logic [XLEN-1:0]        w_res [ALU_OP_W];

  assign w_src1_s = src1;
  assign w_src2_s = src2;
  assign w_lt_s   = w_src1_s < w_src2_s;
  assign w_lt_u   = src1 < src2;

  always_comb begin
    for (int i = 0; i < ALU_OP_W; i++) w_res[i] = '0;
    w_res[ALU_ADD_BIT]  = src1 + src2;
    w_res[ALU_SUB_BIT]  = src1 - src2;
    w_res[ALU_AND_BIT]  = src1 & src2;
    w_res[ALU_OR_BIT]   = src1 | src2;
    w_res[ALU_XOR_BIT]  = src1 ^ src2;
    w_res[ALU_SLT_BIT]  = {{(XLEN-1){1'b0}}, w_lt_s};
    w_res[ALU_SLTU_BIT] = {{(XLEN-1){1'b0}}, w_lt_u};
    w_res[ALU_SLL_BIT]  = src1 << src2[SHAMT_W-1:0];
  end

  // AND-OR select: no op gives 0, an illegal multi-hot op ORs the chosen results.
  always_comb begin
    alu_result = '0;
    for (int i = 0; i < ALU_OP_W; i++)
      alu_result = alu_result | ({XLEN{alu_op[i]}} & w_res[i]);
  end

  decoder3_8_oh u_funct3_dec (
    .i_sel    (funct3),
    .o_onehot (funct3_d)
  );
endmodule

// File: tb/tb_exec_regfile_alu.sv
// Directed bench for exec_regfile_alu: register file, ALU and funct3 decoder.
module tb_exec_regfile_alu;
  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [7:0]  alu_op;
  logic [31:0] alu_result;
  logic [2:0]  funct3;
  logic [7:0]  funct3_d;

  int n_cmp = 0;
  int n_err = 0;

  exec_regfile_alu dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .src1       (src1),
    .src2       (src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .funct3     (funct3),
    .funct3_d   (funct3_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    alu_op = op; src1 = a; src2 = b;
    #1;
    check(tag, alu_result, exp);
  endtask

  initial begin
    reset = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    raddr1 = 5'd5; raddr2 = 5'd5; src1 = '0; src2 = '0; alu_op = '0; funct3 = '0;
    #12;
    check("reset_rd1", rdata1, 32'h0);
    check("reset_rd2", rdata2, 32'h0);
    reset = 1'b1;
    tick();

    // Write x5 then reset asynchronously mid-run
    wen = 1'b1; waddr = 5'd5; wdata = 32'h1234;
    tick();
    wen = 1'b0;
    #1;
    check("x5_written", rdata1, 32'h1234);
    reset = 1'b0;
    #1;
    check("x5_in_reset", rdata1, 32'h0);
    tick();
    tick();
    check("x5_held_reset", rdata1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("x5_after_release", rdata1, 32'h0);

    // x0 is hard-wired
    wen = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
    tick();
    raddr1 = 5'd0;
    #1;
    check("x0_read", rdata1, 32'h0);
    waddr = 5'd1;
    tick();
    wen = 1'b0; raddr2 = 5'd1;
    #1;
    check("x1_read_p2", rdata2, 32'hDEAD_BEEF);

    // Same-cycle read/write: old value until the edge
    wen = 1'b1; waddr = 5'd7; wdata = 32'h11;
    tick();
    wdata = 32'h55; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check("rw_old", rdata1, 32'h11);
    tick();
    wen = 1'b0;
    #1;
    check("rw_new", rdata1, 32'h55);
    check("rw_new_p2", rdata2, 32'h55);
    raddr2 = 5'd1;
    #1;
    check("x1_retained", rdata2, 32'hDEAD_BEEF);

    alu(8'h01, 32'h8000_0000, 32'h4,         32'h8000_0004, "add_pc");
    alu(8'h01, 32'hFFFF_FFFF, 32'h1,         32'h0,         "add_wrap");
    alu(8'h01, 32'h8000_0010, 32'hFFFF_FFF0, 32'h8000_0000, "add_neg");
    alu(8'h02, 32'h5,         32'h7,         32'hFFFF_FFFE, "sub");
    alu(8'h04, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, "and");
    alu(8'h08, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, "or");
    alu(8'h10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, "xor");
    alu(8'h20, 32'hFFFF_FFFF, 32'h1,         32'h1,         "slt_neg");
    alu(8'h20, 32'h5,         32'h3,         32'h0,         "slt_pos");
    alu(8'h40, 32'hFFFF_FFFF, 32'h1,         32'h0,         "sltu_big");
    alu(8'h40, 32'h1,         32'hFFFF_FFFF, 32'h1,         "sltu_small");
    alu(8'h80, 32'h1,         32'd31,        32'h8000_0000, "sll31");
    alu(8'h80, 32'h3,         32'h0000_0024, 32'h30,        "sll_shamt5");
    alu(8'h00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         "op_zero");
    alu(8'h0C, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, "multihot_and_or");

    for (int k = 0; k < 8; k++) begin
      logic [7:0] exp_oh;
      exp_oh = 8'h00;
      exp_oh[k] = 1'b1;
      funct3 = 3'(k);
      #1;
      check($sformatf("funct3_d_%0d", k), {24'h0, funct3_d}, {24'h0, exp_oh});
      check($sformatf("funct3_ones_%0d", k), 32'($countones(funct3_d)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
